heal_meowth: RTL and testbench

Restores Meowth's on-screen HP bar after a heal event. On a start pulse it adds the heal amount to the current HP, clamps the result at MAX_HP, and streams one green pixel per cycle into the VGA adapter to extend the bar. When finished it returns the new HP and a done pulse to the battle FSM. It performs the inverse of the damage/erase path and shares the same bar geometry and pixel-stream interface.

---
 rtl/heal_meowth_if.sv | 24 ++
 rtl/heal_meowth.sv | 103 ++++++++++
 tb/tb_heal_meowth.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/heal_meowth_if.sv
// Pixel-stream and handshake bundle between the battle FSM (master) and the
// HP-bar heal engine (slave).
interface heal_meowth_if;
  logic       start;
  logic [8:0] heal_amt;
  logic [8:0] hp_in;
  logic       busy;
  logic       done;
  logic [8:0] hp_out;
  logic [8:0] out_x;
  logic [7:0] out_y;
  logic [2:0] colour;
  logic       plot;

  modport master (
    output start, heal_amt, hp_in,
    input  busy, done, hp_out, out_x, out_y, colour, plot
  );

  modport slave (
    input  start, heal_amt, hp_in,
    output busy, done, hp_out, out_x, out_y, colour, plot
  );
endinterface

// File: rtl/heal_meowth.sv
// Meowth HP-bar heal engine: clamps hp+heal at MAX_HP and streams the added bar
// columns as green pixels. Define HEAL_REVIVE_EN to allow healing from HP 0.
module heal_meowth #(
  parameter logic [8:0] MAX_HP = 9'd120,
  parameter logic [8:0] X_LEFT = 9'd184,
  parameter logic [7:0] Y_TOP  = 8'd119,
  parameter logic [2:0] BAR_H  = 3'd4,
  parameter logic [2:0] COLOUR = 3'b010
) (
  input  logic           clock,
  input  logic           reset,
  heal_meowth_if.slave   hm
);

  typedef enum logic [1:0] {IDLE, CALC, DRAW, DONE} state_t;

  state_t     state, next_state;
  logic [8:0] hp_lat, amt_lat, new_hp, hp_out;
  logic [8:0] old_c, new_c;
  logic [9:0] sum_c;
  logic [8:0] out_x;
  logic [7:0] out_y;
  logic [7:0] y_bot;
  logic       last_px;

  assign y_bot = Y_TOP + {5'b0, BAR_H} - 8'd1;

  always_comb begin
    old_c = (hp_lat > MAX_HP) ? MAX_HP : hp_lat;
    sum_c = {1'b0, old_c} + {1'b0, amt_lat};
    new_c = (sum_c > {1'b0, MAX_HP}) ? MAX_HP : sum_c[8:0];
`ifndef HEAL_REVIVE_EN
    // A fainted Meowth stays at 0; old_c is already 0 so CALC goes straight to DONE.
    if (hp_lat == '0) new_c = '0;
`endif
  end

  assign last_px = (out_x == X_LEFT + new_hp - 9'd1) && (out_y == y_bot);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (hm.start) next_state = CALC;
      CALC: next_state = (new_c == old_c) ? DONE : DRAW;
      DRAW: if (last_px) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hp_lat  <= '0;
      amt_lat <= '0;
      new_hp  <= '0;
      out_x   <= '0;
      out_y   <= '0;
      hp_out  <= MAX_HP;
    end else begin
      unique case (state)
        IDLE: if (hm.start) begin
          hp_lat  <= hm.hp_in;
          amt_lat <= hm.heal_amt;
        end
        CALC: begin
          new_hp <= new_c;
          if (new_c == old_c) begin
            hp_out <= new_c;
          end else begin
            out_x <= X_LEFT + old_c;
            out_y <= Y_TOP;
          end
        end
        DRAW: begin
          // y is the inner loop: finish a column before stepping x.
          if (last_px) begin
            hp_out <= new_hp;
          end else if (out_y == y_bot) begin
            out_y <= Y_TOP;
            out_x <= out_x + 9'd1;
          end else begin
            out_y <= out_y + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign hm.busy   = (state != IDLE);
  assign hm.done   = (state == DONE);
  assign hm.plot   = (state == DRAW);
  assign hm.colour = (state == DRAW) ? COLOUR : '0;
  assign hm.out_x  = out_x;
  assign hm.out_y  = out_y;
  assign hm.hp_out = hp_out;

endmodule

// File: tb/tb_heal_meowth.sv
// Scoreboard bench for heal_meowth: expected pixels queued at start, popped per plot.
module tb_heal_meowth;

  logic clock = 1'b0;
  logic reset = 1'b0;

  heal_meowth_if hm();

  heal_meowth dut (
    .clock (clock),
    .reset (reset),
    .hm    (hm)
  );

  always #5 clock = ~clock;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [16:0] px_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model(input int hp, input int amt, output int n, output int nw);
    int old;
    old = (hp > 120) ? 120 : hp;
    nw  = (old + amt > 120) ? 120 : old + amt;
`ifndef HEAL_REVIVE_EN
    if (hp == 0) nw = 0;
`endif
    n = (nw - old) * 4;
    for (int x = old; x < nw; x++)
      for (int y = 0; y < 4; y++)
        px_q.push_back({9'(184 + x), 8'(119 + y)});
  endtask

  task automatic sample_plot();
    logic [16:0] e;
    if (hm.plot) begin
      check("colour", hm.colour, 3'b010);
      if (px_q.size() == 0) check("extra_plot", hm.plot, 0);
      else begin
        e = px_q.pop_front();
        check("pixel", {hm.out_x, hm.out_y}, e);
      end
    end
  endtask

  task automatic run_heal(input int hp, input int amt, input bit poke);
    int n, nw, c;
    bit got_done;
    model(hp, amt, n, nw);
    @(negedge clock);
    hm.hp_in = 9'(hp); hm.heal_amt = 9'(amt); hm.start = 1'b1;
    @(posedge clock); #1;
    hm.start = 1'b0;
    c = 1; got_done = 0;
    check("busy_calc", hm.busy, 1);
    if (poke) begin hm.start = 1'b1; hm.heal_amt = 9'd99; end
    while (!got_done && c < n + 10) begin
      if (c == 2) hm.start = 1'b0;
      sample_plot();
      if (hm.done) begin
        got_done = 1;
        check("done_cycle", c, n + 2);
        check("hp_out", hm.hp_out, nw);
        check("busy_done", hm.busy, 1);
        check("missing_px", px_q.size(), 0);
      end else begin
        @(posedge clock); #1; c++;
      end
    end
    check("done_seen", got_done, 1);
    if (poke) hm.start = 1'b1;
    @(posedge clock); #1;
    hm.start = 1'b0;
    check("idle_busy", hm.busy, 0);
    check("idle_done", hm.done, 0);
    check("hp_hold", hm.hp_out, nw);
    px_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    int n, nw, plots;
    hm.start = 1'b0; hm.hp_in = '0; hm.heal_amt = '0;
    #12;
    check("rst_busy", hm.busy, 0);
    check("rst_done", hm.done, 0);
    check("rst_plot", hm.plot, 0);
    check("rst_colour", hm.colour, 0);
    check("rst_x", hm.out_x, 0);
    check("rst_y", hm.out_y, 0);
    check("rst_hp", hm.hp_out, 120);
    @(negedge clock); reset = 1'b1;

    run_heal(96, 12, 1'b1);
    run_heal(110, 30, 1'b0);
    run_heal(120, 5, 1'b0);
    run_heal(200, 10, 1'b0);
    run_heal(0, 8, 1'b0);
    run_heal(50, 400, 1'b0);
    run_heal(30, 0, 1'b0);

    // Abort mid-draw on the 10th plot.
    model(50, 30, n, nw);
    @(negedge clock);
    hm.hp_in = 9'd50; hm.heal_amt = 9'd30; hm.start = 1'b1;
    @(posedge clock); #1;
    hm.start = 1'b0;
    plots = 0;
    for (int i = 0; i < 40 && plots < 10; i++) begin
      @(posedge clock); #1;
      sample_plot();
      if (hm.plot) plots++;
    end
    check("tenth_plot", plots, 10);
    reset = 1'b0;
    #1;
    check("abort_plot", hm.plot, 0);
    check("abort_busy", hm.busy, 0);
    check("abort_done", hm.done, 0);
    check("abort_hp", hm.hp_out, 120);
    px_q.delete();
    @(negedge clock); reset = 1'b1;

    run_heal(7, 3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
